// File: rtl/pkg_bus_8088.sv
// Shared types and constants for the 8088 external bus (Direction / RD_WR / Data).
package pkg_bus_8088;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    // Value presented on a read that hits no storage
    localparam logic [DATA_W-1:0] BUS_IDLE_DATA = 16'hFFFF;

    typedef enum logic {
        leer     = 1'b0,
        escribir = 1'b1
    } operacion;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: DEPTH x 8 byte storage. One registered 16-bit read of the
// byte pair {off+1, off} and one 16-bit write of the same pair, both with the
// upper byte address wrapping modulo DEPTH. Contents are never reset.
module mem_byte_array #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_off_i,
    output logic [15:0]   rd_data_o,
    input  logic          we_i,
    input  logic [AW-1:0] wr_off_i,
    input  logic [15:0]   wr_data_i
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_addr [2];
    logic [AW-1:0] wr_addr [2];

    // Lane 0 is the low (even-side) byte, lane 1 the following byte
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign rd_addr[gi] = rd_off_i + AW'(gi);
        assign wr_addr[gi] = wr_off_i + AW'(gi);
    end

    // Little-endian pair write: low byte at off, high byte at off+1
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr[0]] <= wr_data_i[7:0];
            mem_q[wr_addr[1]] <= wr_data_i[15:8];
        end
    end

    // Registered pair read, refreshed every cycle
    always_ff @(posedge clk) begin
        rd_data_o <= {mem_q[rd_addr[1]], mem_q[rd_addr[0]]};
    end

endmodule

// File: rtl/mem_responder_8088.sv
// mem_responder_8088: slave end of the 8088 external bus. Latches a request
// on EN, waits WAIT_STATES cycles, then gives a one-cycle Ready (with Error)
// while serving or storing a 16-bit little-endian word.
// Optional macro ROM_REGION_EN: offsets below ROM_BYTES become write-protected.
module mem_responder_8088
    import pkg_bus_8088::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'h00000,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_STATES = 2,
    parameter int                ROM_BYTES   = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EN,
    input  logic              RD_WR,
    input  logic [ADDR_W-1:0] Direction,
    inout  wire  [DATA_W-1:0] Data,
    output logic              Ready,
    output logic              Error
);

    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = ADDR_W + 1;

    // Decode window in one extra bit so BASE_ADDR + DEPTH never wraps
    localparam logic [AW1-1:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [AW1-1:0] HI_ADDR = LO_ADDR + AW1'(DEPTH) - AW1'(1);

    resp_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    operacion          op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [AW-1:0]     off_q;
    logic              in_range_q;
    logic              err_q;
    logic              wr_ok_q;

    logic              accept;
    logic [AW1-1:0]    dir_ext;
    logic              in_range_now;
    logic              prot_now;
    logic [AW-1:0]     off_now;
    logic [AW-1:0]     rd_off;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] rd_value;
    logic              drive_data;
    logic              mem_we;

    assign accept       = (state_q == IDLE) && EN;
    assign dir_ext      = {1'b0, Direction};
    // Both bytes of the word must lie inside the window
    assign in_range_now = (dir_ext >= LO_ADDR) && ((dir_ext + AW1'(1)) <= HI_ADDR);
    assign off_now      = AW'(Direction - BASE_ADDR);

`ifdef ROM_REGION_EN
    // In range means off+1 <= DEPTH-1, so off < ROM_BYTES covers both bytes
    assign prot_now = RD_WR && in_range_now && ((Direction - BASE_ADDR) < ADDR_W'(ROM_BYTES));
`else
    assign prot_now = 1'b0;
`endif

    // State register plus the request captured at the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= leer;
            wdata_q    <= '0;
            off_q      <= '0;
            in_range_q <= 1'b0;
            err_q      <= 1'b0;
            wr_ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q       <= operacion'(RD_WR);
                wdata_q    <= Data;
                off_q      <= off_now;
                in_range_q <= in_range_now;
                err_q      <= !in_range_now || prot_now;
                wr_ok_q    <= RD_WR && in_range_now && !prot_now;
            end
        end
    end

    // Next state: IDLE -> (WAIT x WAIT_STATES) -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (EN) begin
                    cnt_d   = 4'(WAIT_STATES - 1);
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: Ready/Error pulse and the write commit in RESP, suppressed by a
    // reset arriving in that cycle; the bus is driven only for a read response
    always_comb begin
        Ready      = 1'b0;
        Error      = 1'b0;
        mem_we     = 1'b0;
        drive_data = 1'b0;
        if ((state_q == RESP) && !reset) begin
            Ready  = 1'b1;
            Error  = err_q;
            mem_we = wr_ok_q;
        end
        if ((state_q == RESP) && (op_q == leer)) begin
            drive_data = 1'b1;
        end
    end

    // Read at the accept edge uses the live address so zero-wait reads work
    assign rd_off   = (state_q == IDLE) ? off_now : off_q;
    assign rd_value = in_range_q ? mem_rd_data : BUS_IDLE_DATA;
    assign Data     = drive_data ? rd_value : {DATA_W{1'bz}};

    mem_byte_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rd_off_i  (rd_off),
        .rd_data_o (mem_rd_data),
        .we_i      (mem_we),
        .wr_off_i  (off_q),
        .wr_data_i (wdata_q)
    );

endmodule

// File: doc/mem_responder_8088.md
Name: mem_responder_8088

Overview:
Bus-side memory responder for the 8088 core: the slave end of the DUT's external bus (Direction, RD_WR, Data).
- Accepts read/write requests from the core, inserts programmable wait states, returns Ready, and serves or stores 16-bit little-endian data from a byte-addressed array.
- Synthesizable replacement for the testbench-driven Data_drive/RD_WR_drive path. Used in the integrated system and in the bench.

Parameters:
- BASE_ADDR, 20'h00000, first byte address decoded by this responder.
- DEPTH, 1024, bytes of storage; power of two, at least 2.
- WAIT_STATES, 2, cycles between request acceptance and Ready; 0 to 15.
- ROM_BYTES, 256, size of the write-protected region at BASE_ADDR; only used with ROM_REGION_EN.

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, synchronous, active-high.
- EN, in, 1, request strobe from the core; held high until Ready.
- RD_WR, in, 1, 0 = leer (read), 1 = escribir (write); stable while EN is high.
- Direction, in, 20, byte address; stable while EN is high.
- Data, inout, 16, driven by the core on writes; driven by this block only in the RESP cycle of a read, else 'z.
- Ready, out, 1, one-cycle completion pulse.
- Error, out, 1, valid with Ready; request was out of range, or a protected write.

Behaviour:
- Reset is synchronous and active-high, on clk.
- Values at reset: state = IDLE, Ready = 0, Error = 0, Data released ('z), latched request cleared. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: when EN = 1, latch Direction, RD_WR and Data (write data) at this edge.
  - Compute in_range = (Direction >= BASE_ADDR) and (Direction + 1 <= BASE_ADDR + DEPTH - 1), using a 21-bit compare with no address wrap.
  - Go to WAIT if WAIT_STATES > 0, else go to RESP.
- WAIT: a counter loaded with WAIT_STATES-1 decrements each cycle. At zero, go to RESP. EN/Direction changes during WAIT are ignored because the request is latched.
- RESP (exactly one cycle): Ready = 1 and Error = !in_range. Then go to IDLE.
  - Read, in range: Data = {mem[off+1], mem[off]}, where off = Direction - BASE_ADDR.
  - Read, out of range: Data = 16'hFFFF.
  - Write, in range: mem[off] <= Data[7:0] and mem[off+1] <= Data[15:8], committed at the RESP edge. Data was latched in IDLE.
  - Write, out of range: no memory change.
- Latency: Ready asserts WAIT_STATES+1 cycles after the accept edge.
- The requester drops or changes EN on the edge where it samples Ready. Back-to-back requests are accepted in the IDLE cycle immediately after RESP, giving a throughput of one access per WAIT_STATES+2 cycles.
- A read followed by a write to the same address returns the old data. A write followed by a read returns the new data.
- Reset asserted in WAIT or RESP aborts the access: no memory write, no Ready, Data released next cycle.
- Bus contention rule: Data is driven only while state == RESP and the latched RD_WR == 0.

Optional Feature:
Macro ROM_REGION_EN.
- Defined: offsets below ROM_BYTES are read-only.
  - A write whose off or off+1 falls below ROM_BYTES changes neither byte and returns Ready with Error = 1.
  - Reads of the region are normal.
- Undefined: the whole array is writable, and ROM_BYTES is unused.

Decomposition:
- Package pkg_bus_8088:
  - typedef enum logic {leer = 1'b0, escribir = 1'b1} operacion.
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t.
  - ADDR_W = 20, DATA_W = 16, constant BUS_IDLE_DATA = 16'hFFFF.
- One sub-module, mem_byte_array: DEPTH x 8 storage with a dual-byte read port and a dual-byte write enable, both at off and (off+1) & (DEPTH-1).

Test Plan:
1. Reset, then write 16'hBEEF at 20'h00010 with WAIT_STATES = 2 -> Ready 3 cycles after accept, Error = 0. A subsequent read returns 16'hBEEF, and mem[0x10] = 8'hEF, mem[0x11] = 8'hBE.
2. Read 20'h00400 (beyond DEPTH = 1024) -> Ready with Error = 1, Data = 16'hFFFF. Read 20'h003FF (straddles the top) -> Error = 1.
3. Back-to-back: write 16'h1234 at 20'h0020 held through Ready, then a read of 20'h0020 with EN kept high -> second accept in the cycle after RESP, Data = 16'h1234, no idle gap.
4. Assert reset in the first WAIT cycle of a write of 16'hAAAA at 20'h0030 -> no Ready, Data 'z. A later read of 20'h0030 returns the pre-write value.
5. With WAIT_STATES = 0: read -> Ready on the cycle after accept. Check that Data is driven only in that cycle and is 'z elsewhere.
6. With ROM_REGION_EN defined: write 16'h5555 at 20'h00FF (straddles ROM_BYTES = 256) -> Error = 1 and both bytes are unchanged. A write at 20'h0100 succeeds.
